// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM responder and the load/store unit.
//   state_e      : controller state encoding
//   ZERO_WORD    : all-zero data word
//   SEL_*        : byte-lane selects in big-endian lane order
//                  (lane 0 is [31:24], lane 3 is [7:0])
//   max_wait()   : larger of two wait-state counts, sizes the wait counter
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_W_SETUP = 3'd2,
      ST_W_PULSE = 3'd3,
      ST_W_HOLD  = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam logic [3:0] SEL_B0 = 4'b1000;
   localparam logic [3:0] SEL_B1 = 4'b0100;
   localparam logic [3:0] SEL_B2 = 4'b0010;
   localparam logic [3:0] SEL_B3 = 4'b0001;
   localparam logic [3:0] SEL_H0 = 4'b1100;
   localparam logic [3:0] SEL_H1 = 4'b0011;
   localparam logic [3:0] SEL_W  = 4'b1111;

   function automatic int max_wait(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_ctrl_wait_counter.sv
// Loadable down-counter with a zero flag, used to time strobe widths.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded; a count of N-1 gives an N-cycle wait
//   dec        : decrement, saturating at zero
//   zero       : count is zero
module wait_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Responder for the word-wide SRAM request bus; drives one asynchronous
// SRAM chip with registered active-low strobes and programmable waits.
//   Request side : sram_ce, sram_we, sram_addr_i, sram_sel_i, sram_data_i in;
//                  sram_data_o (registered read word), done, busy out
//   Chip side    : ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
//                  ram_data_o, ram_data_oe out; ram_data_i in
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for sram_ce; latches the request on accept
// ST_RD      | ce/oe low for READ_WAIT cycles, data sampled on last edge
// ST_W_SETUP | ce/be low and bus driven, we high (address/data setup)
// ST_W_PULSE | we low for WRITE_WAIT cycles
// ST_W_HOLD  | we high again, bus still driven (data hold)
// ST_DONE    | done pulse, strobes released, back to idle
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int PADDR_W    = 20,
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sram_ce,
   input  logic               sram_we,
   input  logic [31:0]        sram_addr_i,
   input  logic [3:0]         sram_sel_i,
   input  logic [31:0]        sram_data_i,
   output logic [31:0]        sram_data_o,
   output logic               done,
   output logic               busy,
   output logic [PADDR_W-1:0] ram_addr,
   output logic [3:0]         ram_be_n,
   output logic               ram_ce_n,
   output logic               ram_oe_n,
   output logic               ram_we_n,
   output logic [31:0]        ram_data_o,
   output logic               ram_data_oe,
   input  logic [31:0]        ram_data_i
);

   localparam int MAX_WAIT = max_wait(READ_WAIT, WRITE_WAIT);
   localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

   state_e           state;
   state_e           state_nxt;
   logic [3:0]       sel_q;
   logic [3:0]       sel_cur;
   logic             accept;
   logic             capture;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   logic             ce_n_nxt;
   logic             oe_n_nxt;
   logic             we_n_nxt;
   logic [3:0]       be_n_nxt;
   logic             data_oe_nxt;

   // Byte offset and address bits above the chip's range are not used.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{sram_addr_i[31:PADDR_W+2], sram_addr_i[1:0]};

   wait_counter #(.W(CNT_W)) u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_val   = '0;
      case (state)
         ST_IDLE: begin
            if (sram_ce) begin
               accept = 1'b1;
               if (!sram_we) begin
                  state_nxt = ST_RD;
                  cnt_load  = 1'b1;
                  cnt_val   = RD_LOAD;
               end else if (sram_sel_i != 4'b0000) begin
                  state_nxt = ST_W_SETUP;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_RD: begin
            if (cnt_zero) begin
               state_nxt = ST_DONE;
               capture   = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_W_SETUP: begin
            state_nxt = ST_W_PULSE;
            cnt_load  = 1'b1;
            cnt_val   = WR_LOAD;
         end
         ST_W_PULSE: begin
            if (cnt_zero) begin
               state_nxt = ST_W_HOLD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_W_HOLD: state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered, so the pins
   // change only on clock edges and never glitch.
   always_comb begin
      sel_cur     = (state == ST_IDLE) ? sram_sel_i : sel_q;
      ce_n_nxt    = 1'b1;
      oe_n_nxt    = 1'b1;
      we_n_nxt    = 1'b1;
      be_n_nxt    = 4'b1111;
      data_oe_nxt = 1'b0;
      case (state_nxt)
         ST_RD: begin
            ce_n_nxt = 1'b0;
            oe_n_nxt = 1'b0;
            be_n_nxt = 4'b0000;
         end
         ST_W_SETUP, ST_W_HOLD: begin
            ce_n_nxt    = 1'b0;
            be_n_nxt    = ~sel_cur;
            data_oe_nxt = 1'b1;
         end
         ST_W_PULSE: begin
            ce_n_nxt    = 1'b0;
            we_n_nxt    = 1'b0;
            be_n_nxt    = ~sel_cur;
            data_oe_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q       <= 4'b0000;
         ram_addr    <= '0;
         ram_data_o  <= ZERO_WORD;
         sram_data_o <= ZERO_WORD;
         ram_ce_n    <= 1'b1;
         ram_oe_n    <= 1'b1;
         ram_we_n    <= 1'b1;
         ram_be_n    <= 4'b1111;
         ram_data_oe <= 1'b0;
      end else begin
         if (accept) begin
            sel_q      <= sram_sel_i;
            ram_addr   <= sram_addr_i[PADDR_W+1:2];
            ram_data_o <= sram_data_i;
         end
         if (capture) begin
            sram_data_o <= ram_data_i;
         end
         ram_ce_n    <= ce_n_nxt;
         ram_oe_n    <= oe_n_nxt;
         ram_we_n    <= we_n_nxt;
         ram_be_n    <= be_n_nxt;
         ram_data_oe <= data_oe_nxt;
      end
   end

   assign done = (state == ST_DONE);
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (waits 2/2 and 1/4) sharing request
// inputs, each with its own SRAM chip model. A transaction-level model
// expands every accepted request into the per-cycle pin picture it must
// produce; that picture is compared against the active instance each cycle.
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int PW = 20;

   typedef struct packed {
      logic          ce_n;
      logic          oe_n;
      logic          we_n;
      logic [3:0]    be_n;
      logic          doe;
      logic          busy;
      logic          done;
      logic [PW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   int          act;

   logic          ce_g        [2];
   logic [31:0]   sram_data_o [2];
   logic          done        [2];
   logic          busy        [2];
   logic [PW-1:0] ram_addr    [2];
   logic [3:0]    ram_be_n    [2];
   logic          ram_ce_n    [2];
   logic          ram_oe_n    [2];
   logic          ram_we_n    [2];
   logic [31:0]   ram_data_o  [2];
   logic          ram_data_oe [2];
   logic [31:0]   ram_data_i  [2];

   logic [31:0] mem [2][16];
   logic        mem_init = 1'b0;

   int n_cmp;
   int n_fail;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign ce_g[g] = ce && (act == g);
      assign ram_data_i[g] = (!ram_ce_n[g] && !ram_oe_n[g]) ?
                             mem[g][ram_addr[g][3:0]] : 32'hDEAD_BEEF;
      sram_ctrl #(
         .PADDR_W    (PW),
         .READ_WAIT  (g == 0 ? 2 : 1),
         .WRITE_WAIT (g == 0 ? 2 : 4)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .sram_ce     (ce_g[g]),
         .sram_we     (we),
         .sram_addr_i (addr),
         .sram_sel_i  (sel),
         .sram_data_i (wdata),
         .sram_data_o (sram_data_o[g]),
         .done        (done[g]),
         .busy        (busy[g]),
         .ram_addr    (ram_addr[g]),
         .ram_be_n    (ram_be_n[g]),
         .ram_ce_n    (ram_ce_n[g]),
         .ram_oe_n    (ram_oe_n[g]),
         .ram_we_n    (ram_we_n[g]),
         .ram_data_o  (ram_data_o[g]),
         .ram_data_oe (ram_data_oe[g]),
         .ram_data_i  (ram_data_i[g])
      );
   end

   function automatic logic [31:0] init_val(input int w);
      case (w)
         4:       return 32'h1122_3344;
         8:       return 32'h0123_4567;
         default: return 32'hC0DE_0000 + 32'(w) * 32'h0000_0111;
      endcase
   endfunction

   // Chip model: bytes enabled by be_n are written while ce and we are low.
   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++) mem[i][w] = init_val(w);
         mem_init = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         if (!ram_ce_n[i] && !ram_we_n[i]) begin
            for (int b = 0; b < 4; b++) begin
               if (!ram_be_n[i][b])
                  mem[i][ram_addr[i][3:0]][8*b +: 8] =
                     ram_data_oe[i] ? ram_data_o[i][8*b +: 8] : 8'hEE;
            end
         end
      end
   end

   // ---------------- behavioural model ----------------
   exp_t          q [$];
   exp_t          cur;
   logic [PW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [31:0]   m_rdata;
   logic [31:0]   mmem [2][16];
   logic          m_init = 1'b0;
   logic          pend;
   logic [3:0]    pend_sel;
   logic [3:0]    pend_word;
   logic [31:0]   pend_data;

   function automatic int rw_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int ww_of(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic exp_t mk(input logic ce_n_e, input logic oe_n_e,
                               input logic we_n_e, input logic [3:0] be_n_e,
                               input logic doe_e, input logic busy_e,
                               input logic done_e);
      exp_t e;
      e.ce_n  = ce_n_e;
      e.oe_n  = oe_n_e;
      e.we_n  = we_n_e;
      e.be_n  = be_n_e;
      e.doe   = doe_e;
      e.busy  = busy_e;
      e.done  = done_e;
      e.addr  = m_addr;
      e.wdata = m_wdata;
      e.rdata = m_rdata;
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!m_init) begin
         for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++) mmem[i][w] = init_val(w);
         m_init = 1'b1;
      end
      if (!rst_n) begin
         q.delete();
         m_addr  = '0;
         m_wdata = 32'h0;
         m_rdata = 32'h0;
         pend    = 1'b0;
         cur     = mk(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
      end else begin
         if (q.size() == 0 && !cur.busy && ce) begin
            m_addr  = addr[PW+1:2];
            m_wdata = wdata;
            if (!we) begin
               for (int k = 0; k < rw_of(act); k++)
                  q.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0));
               m_rdata = mmem[act][addr[5:2]];
            end else if (sel != 4'h0) begin
               q.push_back(mk(1'b0, 1'b1, 1'b1, ~sel, 1'b1, 1'b1, 1'b0));
               for (int k = 0; k < ww_of(act); k++)
                  q.push_back(mk(1'b0, 1'b1, 1'b0, ~sel, 1'b1, 1'b1, 1'b0));
               q.push_back(mk(1'b0, 1'b1, 1'b1, ~sel, 1'b1, 1'b1, 1'b0));
               pend      = 1'b1;
               pend_sel  = sel;
               pend_word = addr[5:2];
               pend_data = wdata;
            end
            q.push_back(mk(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1));
         end
         cur = (q.size() != 0) ? q.pop_front()
                               : mk(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
         // The chip takes the data once the write pulse is seen.
         if (pend && !cur.we_n) begin
            for (int b = 0; b < 4; b++)
               if (pend_sel[b]) mmem[act][pend_word][8*b +: 8] = pend_data[8*b +: 8];
            pend = 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("ram_ce_n",    32'(ram_ce_n[act]),    32'(cur.ce_n));
      chk("ram_oe_n",    32'(ram_oe_n[act]),    32'(cur.oe_n));
      chk("ram_we_n",    32'(ram_we_n[act]),    32'(cur.we_n));
      chk("ram_be_n",    32'(ram_be_n[act]),    32'(cur.be_n));
      chk("ram_data_oe", 32'(ram_data_oe[act]), 32'(cur.doe));
      chk("busy",        32'(busy[act]),        32'(cur.busy));
      chk("done",        32'(done[act]),        32'(cur.done));
      chk("ram_addr",    32'(ram_addr[act]),    32'(cur.addr));
      chk("ram_data_o",  ram_data_o[act],       cur.wdata);
      chk("sram_data_o", sram_data_o[act],      cur.rdata);
      for (int i = 0; i < 2; i++)
         chk("oe_bus_conflict", 32'(ram_data_oe[i] & ~ram_oe_n[i]), 32'h0);
   endtask

   int            lat;
   int            n_oe;
   int            n_we;
   int            n_ce;
   logic [3:0]    be_seen;
   logic [PW-1:0] addr_seen;

   // Present a request (called at a negedge) and hold it until done.
   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
      we = w; addr = a; sel = s; wdata = d; ce = 1'b1;
      lat = 0; n_oe = 0; n_we = 0; n_ce = 0;
      be_seen = 4'hF; addr_seen = '0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (!ram_ce_n[act]) begin
            n_ce++;
            be_seen   = ram_be_n[act];
            addr_seen = ram_addr[act];
         end
         if (!ram_oe_n[act]) n_oe++;
         if (!ram_we_n[act]) n_we++;
         if (done[act]) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
      end
   endtask

   task automatic idle_gap();
      ce = 1'b0;
      we = 1'($urandom);
      addr = $urandom;
      sel = 4'($urandom);
      wdata = $urandom;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ce = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic random_run(input int n);
      logic       b2b = 1'b0;
      logic       w;
      logic [3:0] s;
      int         exp_lat;
      for (int t = 0; t < n; t++) begin
         w = ($urandom_range(0, 1) == 1);
         s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         issue(w, $urandom, s, $urandom);
         if (!w)            exp_lat = rw_of(act) + 1;
         else if (s == 4'h0) exp_lat = 1;
         else               exp_lat = ww_of(act) + 3;
         if (b2b) exp_lat++;
         chk("rand_latency", 32'(lat), 32'(exp_lat));
         b2b = ($urandom_range(0, 2) == 0);
         if (!b2b) idle_gap();
      end
      idle_gap();
   endtask

   int n_done;

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; wdata = 32'h0;
      act = 0;
      tick();
      tick();
      chk("rst_busy",   32'(busy[0]),        32'h0);
      chk("rst_done",   32'(done[0]),        32'h0);
      chk("rst_ce_n",   32'(ram_ce_n[0]),    32'h1);
      chk("rst_be_n",   32'(ram_be_n[0]),    32'hF);
      chk("rst_rdata",  sram_data_o[0],      32'h0);
      rst_n = 1'b1;
      tick();

      // read of word 4
      issue(1'b0, 32'h0000_0010, SEL_W, 32'h0);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_oe_cycles", 32'(n_oe), 32'd2);
      chk("rd_addr", 32'(addr_seen), 32'd4);
      chk("rd_data", sram_data_o[0], 32'h1122_3344);
      idle_gap();

      // byte write into lane 1 of word 8
      issue(1'b1, 32'h0000_0021, SEL_B1, 32'hABAB_ABAB);
      chk("wr_latency", 32'(lat), 32'd5);
      chk("wr_be_n", 32'(be_seen), 32'b1011);
      chk("wr_we_cycles", 32'(n_we), 32'd2);
      idle_gap();
      issue(1'b0, 32'h0000_0020, SEL_W, 32'h0);
      chk("wr_readback", sram_data_o[0], 32'h01AB_4567);
      idle_gap();

      // null write
      issue(1'b1, 32'h0000_0044, 4'b0000, 32'h1234_5678);
      chk("null_latency", 32'(lat), 32'd1);
      chk("null_strobes", 32'(n_ce + n_oe + n_we), 32'd0);
      idle_gap();

      // back-to-back reads with sram_ce held high
      issue(1'b0, 32'h0000_0010, SEL_W, 32'h0);
      issue(1'b0, 32'h0000_0020, SEL_W, 32'h0);
      chk("b2b_latency", 32'(lat), 32'd4);
      chk("b2b_data", sram_data_o[0], 32'h01AB_4567);
      idle_gap();

      // reset during the write pulse
      we = 1'b1; addr = 32'h0000_0030; sel = SEL_W; wdata = 32'h5555_AAAA; ce = 1'b1;
      tick();
      tick();
      chk("pulse_we_low", 32'(ram_we_n[0]), 32'h0);
      #2 rst_n = 1'b0;
      ce = 1'b0;
      #1;
      chk("abort_we_n", 32'(ram_we_n[0]),    32'h1);
      chk("abort_doe",  32'(ram_data_oe[0]), 32'h0);
      chk("abort_busy", 32'(busy[0]),        32'h0);
      chk("abort_ce_n", 32'(ram_ce_n[0]),    32'h1);
      tick();
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done[0]) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);

      random_run(60);

      // second instance: READ_WAIT=1, WRITE_WAIT=4
      act = 1;
      do_reset();
      issue(1'b0, 32'h0000_0010, SEL_W, 32'h0);
      chk("i1_rd_latency", 32'(lat), 32'd2);
      chk("i1_rd_data", sram_data_o[1], 32'h1122_3344);
      idle_gap();
      issue(1'b1, 32'h0000_0004, SEL_H1, 32'hCAFE_F00D);
      chk("i1_wr_latency", 32'(lat), 32'd7);
      chk("i1_wr_we_cycles", 32'(n_we), 32'd4);
      idle_gap();
      random_run(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Responder for the word-wide SRAM request bus that the load/store unit drives (`ce`/`we`/`addr`/`sel`/`data`). It converts each request into a timed access on one off-chip asynchronous SRAM chip, with active-low strobes, programmable wait states and a one-cycle `done` pulse. Read data is returned as a registered full 32-bit word in big-endian lane order. It sits between the memory stage and the board SRAM pins; the top level owns the tristate buffer.

## Interface
- `PADDR_W`, 20, physical word-address width driven to the chip
- `READ_WAIT`, 2, cycles `ram_oe_n` is held low before read data is sampled (≥1)
- `WRITE_WAIT`, 2, cycles `ram_we_n` is held low (≥1)
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sram_ce`  in  1  request valid; held stable with all request fields until `done`
- `sram_we`  in  1  1 = write, 0 = read
- `sram_addr_i`  in  32  byte address; bits [1:0] ignored (lanes come from `sram_sel_i`)
- `sram_sel_i`  in  4  write byte enables; bit3→[31:24] … bit0→[7:0]; ignored on reads
- `sram_data_i`  in  32  write data, already lane-replicated by the initiator
- `sram_data_o`  out  32  read data, registered, holds until the next read completes
- `done`  out  1  one-cycle pulse: access finished
- `busy`  out  1  high in every state except IDLE
- `ram_addr`  out  PADDR_W  `sram_addr_i[PADDR_W+1:2]`, latched at accept
- `ram_be_n`  out  4  active-low byte enables
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`  out  1 each  chip strobes, active low
- `ram_data_o`  out  32  write data to pins
- `ram_data_oe`  out  1  1 = drive `ram_data_o` onto the pins
- `ram_data_i`  in  32  data from pins

## Operation
- States: IDLE, RD, W_SETUP, W_PULSE, W_HOLD, DONE.
- IDLE: when `sram_ce`=1, latch address, sel, data and we.
  - Read → RD.
  - Write with sel≠0000 → W_SETUP.
  - Write with sel=0000 → DONE directly; no chip strobes.
- RD, READ_WAIT cycles: `ram_ce_n`=0, `ram_oe_n`=0, `ram_be_n`=0000, `ram_data_oe`=0. On the last RD cycle's closing edge, capture `ram_data_i` into `sram_data_o`.
- W_SETUP, 1 cycle: `ram_ce_n`=0, `ram_be_n`=~sel, `ram_data_oe`=1, `ram_we_n`=1.
- W_PULSE, WRITE_WAIT cycles: as W_SETUP, but `ram_we_n`=0.
- W_HOLD, 1 cycle: `ram_we_n`=1; ce, be and data stay driven.
- DONE, 1 cycle: `done`=1, all strobes deasserted → IDLE.
- Back-to-back: in the IDLE cycle after DONE, a still-high `sram_ce` is treated as a new request. The initiator must change or drop its request on the `done` edge.
- `ram_data_oe` and `ram_oe_n`=0 are never both asserted. Writes release the bus in DONE; reads never drive it.
- One wait counter, width clog2(max(READ_WAIT, WRITE_WAIT))+1. It loads on state entry and counts down.
- All `ram_*` outputs are registered (glitch-free strobes).

## Timing
- Reset values (asynchronous): state IDLE; `ram_ce_n`=`ram_oe_n`=`ram_we_n`=1; `ram_be_n`=1111; `ram_addr`=0; `ram_data_o`=0; `ram_data_oe`=0; `sram_data_o`=0; `done`=0; `busy`=0.
- Read latency: accept edge E → `done` high in cycle E+READ_WAIT+1. Default: 3 cycles after accept.
- Write latency: `done` in cycle E+WRITE_WAIT+3. Default: 5.
- Null write (sel=0000): `done` in cycle E+1.
- Reset mid-access: strobes deassert and the bus releases immediately. Aborted reads leave `sram_data_o`=0. No `done` pulse is produced.
- `sram_ce` dropped mid-access (protocol violation): the access runs to completion using the latched fields.

## Structure
- Shared package/`def.vh`: state encoding constants; `ZERO_WORD`; lane-select constants `SEL_B0..SEL_B3`, `SEL_H0`, `SEL_H1`, `SEL_W`, shared with the load/store unit.
- One natural sub-module: `wait_counter` (load/decrement/zero flag), reusable by the flash controller.

## Test plan
- Read addr 0x0000_0010 with the chip model holding 0x1122_3344 at word 4 → `ram_addr`=4, `ram_oe_n` low for 2 cycles, `done` at E+3, `sram_data_o`=0x1122_3344.
- Write sel=0100, data=0xABABABAB at addr 0x21 → `ram_be_n`=1011, `ram_we_n` low for exactly cycles E+2..E+3, `done` at E+5; readback gives byte [23:16]=0xAB, other bytes unchanged.
- Write sel=0000 → no strobe ever asserted, `done` at E+1.
- `sram_ce` held high across two reads → the second accept occurs in the cycle after DONE, with no idle gap beyond that cycle.
- `rst_n` pulled low during W_PULSE → `ram_we_n`=1, `ram_data_oe`=0 and `busy`=0 within the same cycle; no `done` pulse.
- Run with READ_WAIT=1, WRITE_WAIT=4 → latencies are 2 and 7 cycles; a bus monitor never sees `ram_data_oe` and `ram_oe_n`=0 asserted together.
